txd_scheduler: RTL and testbench
================================

Name: txd_scheduler

Overview:
- Round-robin scheduler that shares one TxD serial transmitter between N_REQ result producers (e.g. max-angle, min-angle and obstacle-alert processors).
- Captures the winning requester's 48-bit payload and drives the TxD data, header and flashin inputs.
- Sequences the TxD flashin load/start protocol, tracks tx_busy to frame completion, and enforces an inter-frame gap.
- Sits between the processing blocks and TxD; TxD's clock and reset are shared with this block.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- IDW, 2, width of grant_id; must be ≥ clog2(N_REQ).
- HEADER, 16'h55AA, LiDAR header driven to TxD.
- FLASH_LEN, 2, cycles flashin is held high per frame; minimum 2.
- TIMEOUT, 8, max cycles in ARM waiting for tx_busy to rise.
- BUSY_MAX, 72, max cycles in SEND waiting for tx_busy to fall.
- GAP_LEN, 4, idle cycles between frames; 0 is allowed.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  N_REQ  per-requester request; held high until ack.
- payload  in  N_REQ*48  requester i payload in bits [48*i+47:48*i].
- ack  out  N_REQ  one-cycle pulse; the payload has been captured.
- lidar_header  out  16  constant HEADER to TxD.
- data  out  48  captured payload to TxD; stable from LOAD until the next grant.
- flashin  out  1  TxD load/start strobe.
- tx_busy  in  1  TxD busy flag.
- grant_id  out  IDW  index of the last granted requester.
- sched_busy  out  1  high whenever state ≠ IDLE.
- timeout_err  out  1  sticky error flag.
- err_clear  in  1  clears timeout_err.
- frame_count  out  16  count of completed frames; wraps FFFF→0000.

Behaviour:
- Reset values:
  - flashin=0, ack=0, data=0, grant_id=0, sched_busy=0, timeout_err=0, frame_count=0.
  - RR pointer=N_REQ-1, so requester 0 wins first; state=IDLE.
  - lidar_header=HEADER always, including during reset.
- Reset asserted mid-frame: all registers return to reset values immediately (asynchronous), including flashin dropping to 0. Any request in progress is abandoned without ack if not yet granted.
- IDLE:
  - Arbitration is evaluated only in IDLE, when any req is high.
  - Search starts at pointer+1 modulo N_REQ; the first set bit wins (g).
  - On that edge: data←payload[g], grant_id←g, pointer←g, ack[g]=1 for exactly one cycle, flashin←1, state→LOAD.
- Requester rules:
  - A requester that drops req before ack is simply not granted.
  - req still high in the cycle after ack counts as a new request.
- LOAD:
  - flashin stays high for FLASH_LEN cycles total, counted from the grant edge.
  - Then flashin←0, state→ARM, timer←0.
- ARM:
  - tx_busy=1 → state→SEND, timer←0.
  - Otherwise timer increments; when timer reaches TIMEOUT-1 with tx_busy still 0: timeout_err←1, state→GAP.
  - Nominal TxD raises tx_busy 2 cycles after flashin falls.
- SEND:
  - tx_busy=0 → frame_count+1, state→GAP.
  - Otherwise timer increments; when timer reaches BUSY_MAX-1: timeout_err←1, state→GAP, frame_count not incremented.
- GAP: hold for GAP_LEN cycles, then state→IDLE. GAP_LEN=0 goes straight to IDLE on the next edge.
- Latency: nominal frame occupies FLASH_LEN + 2 + 64 + GAP_LEN cycles, ±1 for TxD state 11.
- Error flag: err_clear=1 clears timeout_err; if a new timeout occurs in the same cycle, set wins.
- Inputs outside IDLE:
  - req is ignored outside IDLE.
  - payload changes after grant do not affect data.

Test Plan:
- Single request: reset released, req=3'b001, payload[0]=48'hC957_FFCF_C002 → ack[0] pulses 1 cycle; flashin high 2 cycles; data=48'hC957FFCFC002; TxD shifts 64 bits MSB-first starting 0x55,0xAA; frame_count=1; returns to IDLE after GAP_LEN.
- Round-robin: req=3'b111 held, each dropped after its ack → grant order 0,1,2; three ack pulses separated by ≥ one frame; frame_count=3.
- Fairness/re-request: req[0] held continuously, req[2] high → grant order 0,2,0,2.
- ARM timeout: tx_busy tied 0, req=3'b010 → timeout_err=1 exactly TIMEOUT cycles after flashin falls; frame_count stays 0; err_clear=1 → flag 0.
- SEND timeout: tx_busy forced 1 → timeout_err set after BUSY_MAX cycles in SEND; scheduler returns to IDLE.
- Reset mid-SEND: reset=0 during bit 20 → flashin=0, sched_busy=0, frame_count=0 immediately; after release, a pending req=3'b001 is granted normally.

Source files
------------

// File: rtl/txd_scheduler.sv
// Round-robin arbiter that shares one TxD transmitter between N_REQ producers,
// sequencing the flashin load strobe, tx_busy tracking and the inter-frame gap.
module txd_scheduler #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned IDW       = 2,
    parameter logic [15:0] HEADER    = 16'h55AA,
    parameter int unsigned FLASH_LEN = 2,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned BUSY_MAX  = 72,
    parameter int unsigned GAP_LEN   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*48-1:0]  payload,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          lidar_header,
    output logic [47:0]          data,
    output logic                 flashin,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 sched_busy,
    output logic                 timeout_err,
    input  logic                 err_clear,
    output logic [15:0]          frame_count
);

    localparam int unsigned DW = 48;
    localparam int unsigned TW = $clog2(BUSY_MAX + TIMEOUT + FLASH_LEN + GAP_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_SEND,
        S_GAP
    } state_t;

    state_t             state, state_next;
    logic [TW-1:0]      timer, timer_next;
    logic [IDW-1:0]     rr_ptr, ptr_next;
    logic [N_REQ-1:0]   ack_next;
    logic [DW-1:0]      data_next;
    logic               flashin_next;
    logic [IDW-1:0]     grant_next;
    logic               busy_next;
    logic               err_set;
    logic               err_next;
    logic [15:0]        fc_next;

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [DW-1:0]      win_data;
    logic [N_REQ-1:0]   win_onehot;

    assign lidar_header = HEADER;

    // Rotating priority search starting one past the last winner.
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!win_found && req[i] && (((32'(rr_ptr) + k) % N_REQ) == i)) begin
                    win_found     = 1'b1;
                    win_id        = IDW'(i);
                    win_data      = payload[DW*i +: DW];
                    win_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        ptr_next     = rr_ptr;
        ack_next     = '0;
        data_next    = data;
        flashin_next = flashin;
        grant_next   = grant_id;
        fc_next      = frame_count;
        err_set      = 1'b0;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    data_next    = win_data;
                    grant_next   = win_id;
                    ptr_next     = win_id;
                    ack_next     = win_onehot;
                    flashin_next = 1'b1;
                    timer_next   = '0;
                    state_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (timer == TW'(FLASH_LEN - 1)) begin
                    flashin_next = 1'b0;
                    timer_next   = '0;
                    state_next   = S_ARM;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_ARM: begin
                if (tx_busy) begin
                    timer_next = '0;
                    state_next = S_SEND;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    timer_next = '0;
                    state_next = S_GAP;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    fc_next    = frame_count + 16'd1;
                    timer_next = '0;
                    state_next = S_GAP;
                end else if (timer == TW'(BUSY_MAX - 1)) begin
                    err_set    = 1'b1;
                    timer_next = '0;
                    state_next = S_GAP;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_GAP: begin
                // GAP_LEN of 0 or 1 both leave after a single cycle here.
                if ((GAP_LEN <= 1) || (timer == TW'(GAP_LEN - 1))) begin
                    timer_next = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                timer_next = '0;
                state_next = S_IDLE;
            end
        endcase

        // A new timeout wins over a simultaneous clear.
        err_next  = err_set | (timeout_err & ~err_clear);
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            rr_ptr      <= IDW'(N_REQ - 1);
            ack         <= '0;
            data        <= '0;
            flashin     <= 1'b0;
            grant_id    <= '0;
            sched_busy  <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            rr_ptr      <= ptr_next;
            ack         <= ack_next;
            data        <= data_next;
            flashin     <= flashin_next;
            grant_id    <= grant_next;
            sched_busy  <= busy_next;
            timeout_err <= err_next;
            frame_count <= fc_next;
        end
    end

endmodule

// File: tb/tb_txd_scheduler.sv
// Directed bench for txd_scheduler: grant order, flashin framing, timeouts,
// error-flag clear priority and asynchronous reset mid-frame.
module tb_txd_scheduler;

    localparam logic [47:0] P0 = 48'hC957_FFCF_C002;
    localparam logic [47:0] P1 = 48'h1111_2222_3333;
    localparam logic [47:0] P2 = 48'hABCD_EF01_2345;

    logic         clock;
    logic         reset;
    logic [2:0]   req;
    logic [143:0] payload;
    logic [2:0]   ack;
    logic [15:0]  lidar_header;
    logic [47:0]  data;
    logic         flashin;
    logic         tx_busy;
    logic [1:0]   grant_id;
    logic         sched_busy;
    logic         timeout_err;
    logic         err_clear;
    logic [15:0]  frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    txd_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .payload      (payload),
        .ack          (ack),
        .lidar_header (lidar_header),
        .data         (data),
        .flashin      (flashin),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .sched_busy   (sched_busy),
        .timeout_err  (timeout_err),
        .err_clear    (err_clear),
        .frame_count  (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request vector and check the grant that follows on the next edge.
    task automatic grant_step(input logic [2:0] req_v, input logic [2:0] exp_ack,
                              input logic [1:0] exp_id, input logic [47:0] exp_data);
        req = req_v;
        tick();
        check("grant_ack",   64'(ack), 64'(exp_ack));
        check("grant_id",    64'(grant_id), 64'(exp_id));
        check("grant_data",  64'(data), 64'(exp_data));
        check("grant_flash", 64'(flashin), 64'(1));
        check("grant_busy",  64'(sched_busy), 64'(1));
    endtask

    // Nominal TxD: tx_busy rises 2 cycles after flashin falls and is held 64 cycles.
    task automatic finish_frame(input logic [15:0] exp_fc);
        tick();
        check("flash_hold", 64'(flashin), 64'(1));
        check("ack_pulse",  64'(ack), 64'(0));
        tick();
        check("flash_fall", 64'(flashin), 64'(0));
        tick();
        tx_busy = 1'b1;
        tick();
        repeat (63) tick();
        check("send_no_err", 64'(timeout_err), 64'(0));
        tx_busy = 1'b0;
        tick();
        check("frame_count", 64'(frame_count), 64'(exp_fc));
        check("gap_busy",    64'(sched_busy), 64'(1));
        repeat (3) tick();
        check("gap_end_busy", 64'(sched_busy), 64'(1));
        tick();
        check("idle_busy", 64'(sched_busy), 64'(0));
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        payload   = {P2, P1, P0};
        tx_busy   = 1'b0;
        err_clear = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst_flashin", 64'(flashin), 64'(0));
        check("rst_ack",     64'(ack), 64'(0));
        check("rst_data",    64'(data), 64'(0));
        check("rst_grant",   64'(grant_id), 64'(0));
        check("rst_busy",    64'(sched_busy), 64'(0));
        check("rst_err",     64'(timeout_err), 64'(0));
        check("rst_fc",      64'(frame_count), 64'(0));
        check("rst_header",  64'(lidar_header), 64'(16'h55AA));
        reset = 1'b1;
        tick();
        check("idle_no_ack", 64'(ack), 64'(0));

        // Single request; payload changes after grant must not reach data.
        grant_step(3'b001, 3'b001, 2'd0, P0);
        req = 3'b000;
        payload[47:0] = 48'h0000_DEAD_BEEF;
        finish_frame(16'd1);
        check("data_stable", 64'(data), 64'(P0));
        check("header",      64'(lidar_header), 64'(16'h55AA));
        payload = {P2, P1, P0};

        // Round-robin from a fresh pointer: 0,1,2.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        grant_step(3'b111, 3'b001, 2'd0, P0);
        req = 3'b110;
        finish_frame(16'd1);
        grant_step(3'b110, 3'b010, 2'd1, P1);
        req = 3'b100;
        finish_frame(16'd2);
        grant_step(3'b100, 3'b100, 2'd2, P2);
        req = 3'b000;
        finish_frame(16'd3);

        // Fairness with req[0] held continuously: 0,2,0,2.
        grant_step(3'b101, 3'b001, 2'd0, P0);
        finish_frame(16'd4);
        grant_step(3'b101, 3'b100, 2'd2, P2);
        finish_frame(16'd5);
        grant_step(3'b101, 3'b001, 2'd0, P0);
        finish_frame(16'd6);
        grant_step(3'b101, 3'b100, 2'd2, P2);
        req = 3'b000;
        finish_frame(16'd7);

        // ARM timeout: tx_busy never rises; flag sets 8 cycles after flashin falls.
        grant_step(3'b010, 3'b010, 2'd1, P1);
        req = 3'b000;
        tick();
        tick();
        check("arm_flash_fall", 64'(flashin), 64'(0));
        repeat (7) tick();
        check("arm_pre_err", 64'(timeout_err), 64'(0));
        tick();
        check("arm_err",   64'(timeout_err), 64'(1));
        check("arm_fc",    64'(frame_count), 64'(7));
        check("arm_busy",  64'(sched_busy), 64'(1));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("err_cleared", 64'(timeout_err), 64'(0));
        repeat (3) tick();
        check("arm_idle", 64'(sched_busy), 64'(0));

        // SEND timeout after 72 cycles; set wins over a simultaneous clear.
        grant_step(3'b001, 3'b001, 2'd0, P0);
        req = 3'b000;
        tick();
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        repeat (71) tick();
        check("send_pre_err", 64'(timeout_err), 64'(0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tx_busy = 1'b0;
        check("send_err_set_wins", 64'(timeout_err), 64'(1));
        check("send_fc",           64'(frame_count), 64'(7));
        repeat (3) tick();
        check("send_gap_busy", 64'(sched_busy), 64'(1));
        tick();
        check("send_idle", 64'(sched_busy), 64'(0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("send_err_clear", 64'(timeout_err), 64'(0));

        // Asynchronous reset 20 cycles into SEND, request left pending.
        grant_step(3'b001, 3'b001, 2'd0, P0);
        tick();
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        repeat (20) tick();
        check("pre_rst_busy", 64'(sched_busy), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_flashin", 64'(flashin), 64'(0));
        check("mid_rst_busy",    64'(sched_busy), 64'(0));
        check("mid_rst_fc",      64'(frame_count), 64'(0));
        check("mid_rst_data",    64'(data), 64'(0));
        tx_busy = 1'b0;
        tick();
        reset = 1'b1;
        grant_step(3'b001, 3'b001, 2'd0, P0);
        req = 3'b000;
        finish_frame(16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
